div_mnbit_seq: RTL and testbench



---
 rtl/div_mnbit_seq.sv | 118 +++++++++++
 tb/tb_div_mnbit_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_mnbit_seq.sv
// Sequential unsigned restoring divider: N-bit dividend / M-bit divisor, one step per clock.
// Define DIV_ZERO_DETECT_EN to short-circuit zero divisors straight to DONE and raise dz.
module div_mnbit_seq #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         dz
);

  localparam int unsigned CW = $clog2(N + 1);

  if (M < 1) begin : g_bad_m
    $error("div_mnbit_seq: M must be at least 1");
  end
  if (N < M) begin : g_bad_n
    $error("div_mnbit_seq: N must be greater than or equal to M");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state_q;
  logic [N-1:0]  dvd_q;
  logic [M-1:0]  dsr_q;
  logic [N-1:0]  quo_q;
  logic [M:0]    p_q;
  logic [CW-1:0] cnt_q;
`ifdef DIV_ZERO_DETECT_EN
  logic          dz_q;
`endif

  logic [M:0]    p_shift;
  logic [M+1:0]  diff;
  logic          ge;

  // P stays below the divisor between steps, so dropping P[M] on the shift loses nothing
  // unless the divisor is zero, where only the low dividend bits are meant to survive.
  always_comb begin
    p_shift = {p_q[M-1:0], dvd_q[N-1]};
    diff    = {1'b0, p_shift} - {2'b00, dsr_q};
    ge      = ~diff[M+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      dsr_q     <= '0;
      quo_q     <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q   <= dividend;
            dsr_q   <= divisor;
            quo_q   <= '0;
            p_q     <= '0;
            cnt_q   <= CW'(N);
            busy    <= 1'b1;
            state_q <= StCalc;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= (divisor == '0);
            if (divisor == '0) begin
              // Same values the full restoring run would converge to.
              quo_q   <= '1;
              p_q     <= {1'b0, dividend[M-1:0]};
              cnt_q   <= '0;
              state_q <= StDone;
            end
`endif
          end
        end
        StCalc: begin
          dvd_q <= dvd_q << 1;
          quo_q <= (quo_q << 1) | N'(ge);
          p_q   <= ge ? diff[M:0] : p_shift;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          quotient  <= quo_q;
          remainder <= p_q[M-1:0];
`ifdef DIV_ZERO_DETECT_EN
          dz        <= dz_q;
`endif
          state_q   <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_mnbit_seq.sv
// Directed bench for div_mnbit_seq at M=N=4; zero-divisor expectations follow DIV_ZERO_DETECT_EN.
module tb_div_mnbit_seq;

  localparam int unsigned M = 4;
  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         dz;

  int nvec = 0;
  int nerr = 0;

  div_mnbit_seq #(.M(M), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [N-1:0] a, input logic [M-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Edges from acceptance until done is seen; -1 if it never arrives within the budget.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = busy;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  int lat;
  bit bok;
  int dcnt;
  int d1;
  int d2;
  logic [N-1:0] q_at;
  logic [M-1:0] r_at;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_quotient", 32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_dz", 32'(dz), 0);
    #14 rst_n = 1'b1;
    tick();

    // 13 / 4
    start_op(4'd13, 4'd4);
    wait_done(lat, bok);
    check("13/4_latency", 32'(lat), 5);
    check("13/4_busy_held", 32'(bok), 1);
    check("13/4_busy_at_done", 32'(busy), 0);
    check("13/4_q", 32'(quotient), 3);
    check("13/4_r", 32'(remainder), 1);
    check("13/4_dz", 32'(dz), 0);
    tick();
    check("13/4_done_one_cycle", 32'(done), 0);
    check("13/4_q_held", 32'(quotient), 3);

    // 15 / 1 then 5 / 7 issued in the first idle cycle
    start_op(4'd15, 4'd1);
    wait_done(lat, bok);
    check("15/1_latency", 32'(lat), 5);
    check("15/1_q", 32'(quotient), 15);
    check("15/1_r", 32'(remainder), 0);
    start_op(4'd5, 4'd7);
    wait_done(lat, bok);
    check("5/7_latency", 32'(lat), 5);
    check("5/7_q", 32'(quotient), 0);
    check("5/7_r", 32'(remainder), 5);

    // 9 / 0
    start_op(4'd9, 4'd0);
    wait_done(lat, bok);
`ifdef DIV_ZERO_DETECT_EN
    check("9/0_latency", 32'(lat), 1);
    check("9/0_dz", 32'(dz), 1);
`else
    check("9/0_latency", 32'(lat), 5);
    check("9/0_dz", 32'(dz), 0);
`endif
    check("9/0_q", 32'(quotient), 15);
    check("9/0_r", 32'(remainder), 9);
    tick();

    // start pulsed with other operands during CALC must be ignored
    start_op(4'd11, 4'd3);
    bok = busy;
    tick();
    if (!busy) bok = 1'b0;
    dividend = 4'd14;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dcnt = 0;
    d1   = -1;
    q_at = '0;
    r_at = '0;
    for (int i = 1; i <= 12; i++) begin
      if (dcnt == 0 && !busy) bok = 1'b0;
      tick();
      if (done) begin
        dcnt++;
        if (d1 < 0) begin
          d1   = i;
          q_at = quotient;
          r_at = remainder;
        end
      end
    end
    check("ignore_done_count", 32'(dcnt), 1);
    check("ignore_done_edge", 32'(d1), 3);
    check("ignore_busy_steady", 32'(bok), 1);
    check("ignore_q", 32'(q_at), 3);
    check("ignore_r", 32'(r_at), 2);

    // start held high: a new division every N+2 cycles
    dividend = 4'd6;
    divisor  = 4'd2;
    start    = 1'b1;
    d1 = -1;
    d2 = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    start = 1'b0;
    check("held_first_done", 32'(d1), 6);
    check("held_second_done", 32'(d2), 12);
    check("held_q", 32'(quotient), 3);
    check("held_r", 32'(remainder), 0);
    tick();

    // reset in the second CALC cycle
    start_op(4'd13, 4'd4);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_q", 32'(quotient), 0);
    check("midrst_r", 32'(remainder), 0);
    check("midrst_dz", 32'(dz), 0);
    #3 rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("midrst_no_done", 32'(dcnt), 0);
    start_op(4'd12, 4'd5);
    wait_done(lat, bok);
    check("12/5_latency", 32'(lat), 5);
    check("12/5_q", 32'(quotient), 2);
    check("12/5_r", 32'(remainder), 2);

    // full sweep, divisor nonzero
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        start_op(4'(a), 4'(b));
        wait_done(lat, bok);
        check($sformatf("sweep_%0d/%0d_q", a, b), 32'(quotient), 32'(a / b));
        check($sformatf("sweep_%0d/%0d_r", a, b), 32'(remainder), 32'(a % b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
